// File: rtl/uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : FIFO-buffered 8N1 UART transmitter with runtime baud select.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic [2:0]                    baud_set,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          overflow,
   output logic                          Rs232_Tx,
   output logic                          Tx_Done,
   output logic                          uart_state
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int BPS_MAX = CLK_FREQ / 9600;
   localparam int CW      = ($clog2(BPS_MAX) < 1) ? 1 : $clog2(BPS_MAX);

   localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [CW-1:0] CC_ONE  = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            tx_q, tx_d;
   logic [7:0]      data_q, data_d;
   logic [CW-1:0]   bps_q, bps_d;        // holds bit period minus one
   logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
   logic [3:0]      bit_idx_q, bit_idx_d;

   logic [CW-1:0]   bps_sel;
   logic            bit_end;
   logic            pop;
   logic            push;

   always_comb begin
      case (baud_set)
         3'd1:    bps_sel = CW'(CLK_FREQ / 19200  - 1);
         3'd2:    bps_sel = CW'(CLK_FREQ / 38400  - 1);
         3'd3:    bps_sel = CW'(CLK_FREQ / 57600  - 1);
         3'd4:    bps_sel = CW'(CLK_FREQ / 115200 - 1);
         default: bps_sel = CW'(CLK_FREQ / 9600   - 1);
      endcase
   end

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == DEPTH_C);
   assign bit_end  = (clk_cnt_q == bps_q);
   // A pop starts a frame, either from IDLE or chained off the last stop cycle.
   assign pop      = !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
   assign push     = wr_en && (!full || pop);

   always_comb begin
      wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      ovf_d    = wr_en && !push;
      cnt_d    = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (pop && !push) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      data_d    = data_q;
      bps_d     = bps_q;
      clk_cnt_d = clk_cnt_q + CC_ONE;
      bit_idx_d = bit_idx_q;
      if (pop) begin
         state_d   = START;
         tx_d      = 1'b0;
         data_d    = mem_q[rd_ptr_q];
         bps_d     = bps_sel;
         clk_cnt_d = '0;
         bit_idx_d = 4'd0;
      end else if (state_q == IDLE) begin
         tx_d      = 1'b1;
         clk_cnt_d = '0;
         bit_idx_d = 4'd0;
      end else if (bit_end) begin
         clk_cnt_d = '0;
         bit_idx_d = bit_idx_q + 4'd1;
         if (state_q == STOP) begin
            state_d   = IDLE;
            tx_d      = 1'b1;
            bit_idx_d = 4'd0;
         end else if (bit_idx_q == 4'd8) begin
            state_d = STOP;
            tx_d    = 1'b1;
         end else begin
            state_d = DATA;
            tx_d    = data_q[bit_idx_q[2:0]];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         tx_q      <= 1'b1;
         data_q    <= '0;
         bps_q     <= '0;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         tx_q      <= tx_d;
         data_q    <= data_d;
         bps_q     <= bps_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
      end
   end

   assign fifo_cnt   = cnt_q;
   assign overflow   = ovf_q;
   assign Rs232_Tx   = tx_q;
   assign Tx_Done    = (state_q == STOP) && bit_end;
   assign uart_state = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Scoreboard bench for uart_tx_fifo; a line monitor checks frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   // 1.152 MHz gives bit periods of 120, 60, 30, 20 and 10 cycles.
   localparam int CLK_FREQ   = 1_152_000;
   localparam int FIFO_DEPTH = 16;

   typedef struct {
      logic [7:0] data;
      int         bps;
      int         exp_start;   // -1: must follow previous frame with no gap
   } item_t;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic [2:0] baud_set = 3'd4;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full, empty, overflow, Rs232_Tx, Tx_Done, uart_state;
   logic [4:0] fifo_cnt;

   item_t sb[$];
   int cyc = 0;
   int n_chk = 0, n_err = 0;
   int frames_done = 0, aborts = 0, stray = 0, tx_done_cnt = 0;
   int last_end = -100;

   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .Clk(Clk), .Rst(Rst), .baud_set(baud_set), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .fifo_cnt(fifo_cnt), .overflow(overflow),
      .Rs232_Tx(Rs232_Tx), .Tx_Done(Tx_Done), .uart_state(uart_state)
   );

   always #10 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic wr(input logic [7:0] d, input int bps, input int es);
      item_t it;
      it.data = d; it.bps = bps; it.exp_start = es;
      sb.push_back(it);
      wr_en = 1'b1;
      wr_data = d;
      @(negedge Clk);
   endtask

   task automatic wait_idle(input int maxc);
      int n;
      n = 0;
      while (!(uart_state === 1'b0 && empty === 1'b1) && n < maxc) begin
         @(negedge Clk);
         n++;
      end
      chk("idle_reached", int'(n < maxc), 1);
      repeat (3) @(negedge Clk);
   endtask

   initial begin : tx_done_counter
      forever begin
         @(negedge Clk);
         if (Tx_Done === 1'b1) tx_done_cnt++;
      end
   end

   // Line monitor: decodes every frame cycle by cycle against the scoreboard.
   initial begin : monitor
      item_t it;
      int st, b, line_bad, done_bad, busy_bad, n;
      logic expv, aborted;
      forever begin
         @(negedge Clk);
         if (Rst !== 1'b0) continue;
         if (Rs232_Tx === 1'b0) begin
            if (sb.size() == 0) begin
               chk("unexpected_frame", sb.size(), 1);
               n = 0;
               while (Rs232_Tx !== 1'b1 && n < 2000) begin @(negedge Clk); n++; end
               continue;
            end
            it = sb.pop_front();
            st = cyc;
            if (it.exp_start >= 0) chk("start_cycle", st, it.exp_start);
            else                   chk("b2b_start", st, last_end + 1);
            line_bad = 0; done_bad = 0; busy_bad = 0; aborted = 1'b0;
            for (int c = 0; c < 10 * it.bps; c++) begin
               if (c > 0) @(negedge Clk);
               if (Rst !== 1'b0) begin aborted = 1'b1; break; end
               b = c / it.bps;
               expv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : it.data[b-1];
               if (Rs232_Tx !== expv) line_bad++;
               if (Tx_Done !== (c == 10 * it.bps - 1)) done_bad++;
               if (uart_state !== 1'b1) busy_bad++;
            end
            if (aborted) begin
               aborts++;
            end else begin
               chk($sformatf("frame_line_%02h", it.data), line_bad, 0);
               chk("tx_done_position", done_bad, 0);
               chk("uart_state_busy", busy_bad, 0);
               frames_done++;
               last_end = cyc;
            end
         end else if (Tx_Done !== 1'b0 || uart_state !== 1'b0) begin
            stray++;
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int es, n;
      repeat (3) @(negedge Clk);
      chk("rst_tx", Rs232_Tx, 1);
      chk("rst_done", Tx_Done, 0);
      chk("rst_state", uart_state, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_cnt", fifo_cnt, 0);
      #5 Rst = 1'b0;
      @(negedge Clk);

      // single byte
      baud_set = 3'd4;
      wr(8'hAA, 10, cyc + 2);
      wr_en = 1'b0;
      chk("single_cnt", fifo_cnt, 1);
      chk("single_empty", empty, 0);
      chk("single_state_pre", uart_state, 0);
      @(negedge Clk);
      chk("single_start_tx", Rs232_Tx, 0);
      chk("single_state", uart_state, 1);
      chk("single_popped", fifo_cnt, 0);
      wait_idle(500);
      chk("single_frames", frames_done, 1);
      chk("single_done_cnt", tx_done_cnt, 1);

      // burst of three
      wr(8'h55, 10, cyc + 2);
      wr(8'hA5, 10, -1);
      wr(8'h0F, 10, -1);
      wr_en = 1'b0;
      wait_idle(1000);
      chk("burst_frames", frames_done, 4);
      chk("burst_done_cnt", tx_done_cnt, 4);

      // overflow at 9600
      baud_set = 3'd0;
      es = cyc + 2;
      for (int i = 0; i < 17; i++) wr(8'(i), 120, (i == 0) ? es : -1);
      chk("ovf_full", full, 1);
      chk("ovf_cnt16", fifo_cnt, 16);
      chk("ovf_not_yet", overflow, 0);
      wr_en = 1'b1;
      wr_data = 8'h11;
      @(negedge Clk);
      wr_en = 1'b0;
      chk("ovf_pulse", overflow, 1);
      chk("ovf_full_hold", full, 1);
      chk("ovf_cnt_hold", fifo_cnt, 16);
      @(negedge Clk);
      chk("ovf_one_cycle", overflow, 0);
      wait_idle(17 * 1200 + 200);
      chk("ovf_frames", frames_done, 21);

      // baud change mid-frame
      baud_set = 3'd4;
      wr(8'h3C, 10, cyc + 2);
      wr_en = 1'b0;
      repeat (50) @(negedge Clk);
      baud_set = 3'd0;
      wr(8'hC3, 120, -1);
      wr_en = 1'b0;
      wait_idle(2000);
      chk("baud_frames", frames_done, 23);

      // reset mid-frame
      baud_set = 3'd4;
      wr(8'hFF, 10, cyc + 2);
      wr_en = 1'b0;
      repeat (45) @(negedge Clk);
      #5 Rst = 1'b1;
      #1;
      chk("mrst_tx", Rs232_Tx, 1);
      chk("mrst_empty", empty, 1);
      chk("mrst_state", uart_state, 0);
      chk("mrst_cnt", fifo_cnt, 0);
      @(negedge Clk);
      #5 Rst = 1'b0;
      repeat (150) @(negedge Clk);
      chk("mrst_aborts", aborts, 1);
      chk("mrst_no_frame", frames_done, 23);
      chk("mrst_no_done", tx_done_cnt, 23);
      wr(8'h81, 10, cyc + 2);
      wr_en = 1'b0;
      wait_idle(500);
      chk("mrst_after", frames_done, 24);

      // write in the Tx_Done cycle of the last queued frame
      wr(8'h12, 10, cyc + 2);
      wr_en = 1'b0;
      n = 0;
      while (Tx_Done !== 1'b1 && n < 500) begin @(negedge Clk); n++; end
      chk("boundary_done_seen", int'(n < 500), 1);
      wr(8'h34, 10, cyc + 2);
      wr_en = 1'b0;
      wait_idle(500);
      chk("boundary_frames", frames_done, 26);
      chk("final_done_cnt", tx_done_cnt, 26);
      chk("stray_activity", stray, 0);
      chk("scoreboard_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
